button_debounce: RTL

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce.sv | 71 +++++++
 1 files changed

// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer: two-flop synchronizer, per-channel
// stability counter, registered debounced level and press/release strobes.
module button_debounce #(
  parameter int               WIDTH           = 2,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_db,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  // Saturates at the acceptance point so the counter can never wrap.
  function automatic logic [23:0] count_up(input logic [23:0] c);
    return (c < CNT_LAST) ? c + 24'd1 : CNT_LAST;
  endfunction

  // Synchronizer stage: the only reader of btn_raw.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= IDLE_LEVEL;
      s2 <= IDLE_LEVEL;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Debounce stage: each channel runs independently on its own counter.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [23:0] cnt;
    logic        db;
    logic        press;
    logic        rel;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt   <= '0;
        db    <= IDLE_LEVEL[i];
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        press <= 1'b0;
        rel   <= 1'b0;
        if (s2[i] == db) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt   <= '0;
          db    <= s2[i];
          press <= (s2[i] != IDLE_LEVEL[i]);
          rel   <= (s2[i] == IDLE_LEVEL[i]);
        end else begin
          cnt <= count_up(cnt);
        end
      end
    end

    assign btn_db[i]        = db;
    assign press_pulse[i]   = press;
    assign release_pulse[i] = rel;
  end

endmodule
